// File: rtl/calc_pkg.sv
// calc_pkg: operator codes, key kinds, scanner states and keymap decode shared by the calculator
package calc_pkg;

    localparam logic [2:0] OP_NONE = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_MUL  = 3'b100;

    typedef enum logic [2:0] {KEY_DIGIT, KEY_OP, KEY_EQ, KEY_CLR, KEY_NONE} key_kind_t;

    typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_EMIT, ST_WAIT_RELEASE} scan_state_t;

    typedef struct packed {
        key_kind_t  kind;
        logic [3:0] val;
    } key_t;

    function automatic key_t key_decode(input logic [1:0] row, input logic [1:0] col);
        key_t k;
        k.kind = KEY_NONE;
        k.val  = 4'd0;
        if (col == 2'd3) begin
            k.kind = (row == 2'd3) ? KEY_NONE : KEY_OP;
            k.val  = (row == 2'd0) ? {1'b0, OP_ADD} : (row == 2'd1) ? {1'b0, OP_SUB} :
                     (row == 2'd2) ? {1'b0, OP_MUL} : {1'b0, OP_NONE};
        end else if (row == 2'd3) begin
            k.kind = (col == 2'd0) ? KEY_CLR : (col == 2'd1) ? KEY_DIGIT : KEY_EQ;
        end else begin
            k.kind = KEY_DIGIT;
            k.val  = {2'b00, row} * 4'd3 + {2'b00, col} + 4'd1;
        end
        return k;
    endfunction

    function automatic logic [1:0] lowest_row(input logic [3:0] rows_n);
        return !rows_n[0] ? 2'd0 : !rows_n[1] ? 2'd1 : !rows_n[2] ? 2'd2 : 2'd3;
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// keypad_sync: 2-flop synchroniser for the active-low row lines, idles high
module keypad_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] meta_q, meta_d, sync_q, sync_d;

    // two-stage shift toward the synchronised output
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // released keys read as high, so reset to all ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 4'hF;
            sync_q <= 4'hF;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans, debounces and decodes a 4x4 keypad into gencon input events
// Optional auto-repeat of held digit keys is enabled by defining KEYPAD_AUTOREPEAT_EN
module keypad_scanner
    import calc_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 4,
    parameter int REPEAT_SCANS = 64
) (
    input  logic       clk,
    input  logic       RST,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] keypad_input,
    output logic       read_input,
    output logic [2:0] operator_input,
    output logic       equal_input,
    output logic       clear_out
);

    localparam int DW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int MAXC = (DEBOUNCE_CNT > REPEAT_SCANS) ? DEBOUNCE_CNT : REPEAT_SCANS;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [DW-1:0] DWELL_END = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DB        = CW'(DEBOUNCE_CNT);

    logic [3:0]    rows_s;
    scan_state_t   state_q, state_d;
    logic [1:0]    col_q, col_d, row_q, row_d;
    key_t          cand_q, cand_d, hit;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    key_q, key_d;
    logic [2:0]    op_q, op_d;
    logic          read_q, read_d, eq_q, eq_d, clr_q, clr_d;
    logic          sample, any_low;
    logic [1:0]    low_row;
`ifdef KEYPAD_AUTOREPEAT_EN
    logic [CW-1:0] rpt_q, rpt_d;
    localparam logic [CW-1:0] RP = CW'(REPEAT_SCANS);
`endif

    keypad_sync u_sync (
        .clk (clk),
        .rst (RST),
        .d   (row_in),
        .q   (rows_s)
    );

    assign sample  = dwell_q == DWELL_END;
    assign any_low = rows_s != 4'hF;
    assign low_row = lowest_row(rows_s);
    assign hit     = key_decode(low_row, col_q);

    // scan/debounce/emit/release sequencing and next values of every registered output
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        dwell_d = sample ? '0 : dwell_q + DW'(1);
        key_d   = key_q;
        op_d    = op_q;
        read_d  = 1'b0;
        eq_d    = 1'b0;
        clr_d   = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rpt_d   = rpt_q;
`endif
        case (state_q)
            ST_SCAN: if (sample) begin
                if (any_low && hit.kind != KEY_NONE) begin
                    row_d   = low_row;
                    cand_d  = hit;
                    cnt_d   = CW'(1);
                    state_d = (DEBOUNCE_CNT <= 1) ? ST_EMIT : ST_DEBOUNCE;
                end else begin
                    col_d = col_q + 2'd1;
                end
            end
            ST_DEBOUNCE: if (sample) begin
                if (any_low && low_row == row_q) begin
                    cnt_d   = cnt_q + CW'(1);
                    state_d = (cnt_q + CW'(1) == DB) ? ST_EMIT : ST_DEBOUNCE;
                end else begin
                    cnt_d   = '0;
                    col_d   = col_q + 2'd1;
                    state_d = ST_SCAN;
                end
            end
            ST_EMIT: begin
                cnt_d   = '0;
                state_d = ST_WAIT_RELEASE;
                read_d  = cand_q.kind == KEY_DIGIT;
                eq_d    = cand_q.kind == KEY_EQ;
                clr_d   = cand_q.kind == KEY_CLR;
                key_d   = (cand_q.kind == KEY_DIGIT) ? cand_q.val : key_q;
                op_d    = (cand_q.kind == KEY_OP) ? cand_q.val[2:0] :
                          (cand_q.kind == KEY_CLR) ? OP_NONE : op_q;
`ifdef KEYPAD_AUTOREPEAT_EN
                rpt_d   = '0;
`endif
            end
            ST_WAIT_RELEASE: if (sample) begin
                cnt_d = any_low ? '0 : cnt_q + CW'(1);
                if (!any_low && cnt_q + CW'(1) == DB) begin
                    cnt_d   = '0;
                    col_d   = col_q + 2'd1;
                    state_d = ST_SCAN;
                end
`ifdef KEYPAD_AUTOREPEAT_EN
                rpt_d = rows_s[row_q] ? '0 : rpt_q + CW'(1);
                if (!rows_s[row_q] && cand_q.kind == KEY_DIGIT && rpt_q + CW'(1) == RP)
                    state_d = ST_EMIT;
`endif
            end
            default: state_d = ST_SCAN;
        endcase
    end

    // state and outputs; reset aborts any debounce or hold in progress
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q <= ST_SCAN;
            col_q   <= '0;
            row_q   <= '0;
            cand_q  <= '{kind: KEY_NONE, val: 4'd0};
            dwell_q <= '0;
            cnt_q   <= '0;
            key_q   <= '0;
            op_q    <= OP_NONE;
            read_q  <= 1'b0;
            eq_q    <= 1'b0;
            clr_q   <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rpt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            cand_q  <= cand_d;
            dwell_q <= dwell_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            op_q    <= op_d;
            read_q  <= read_d;
            eq_q    <= eq_d;
            clr_q   <= clr_d;
`ifdef KEYPAD_AUTOREPEAT_EN
            rpt_q   <= rpt_d;
`endif
        end
    end

    assign col_out        = ~(4'b0001 << col_q);
    assign keypad_input   = key_q;
    assign read_input     = read_q;
    assign operator_input = op_q;
    assign equal_input    = eq_q;
    assign clear_out      = clr_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: scoreboard bench driving a modelled 4x4 key matrix into keypad_scanner
module tb_keypad_scanner;
    import calc_pkg::*;

    localparam int SD = 4;
    localparam int DB = 2;
    localparam int RS = 8;

    typedef struct packed {
        logic [1:0] kind;
        logic [3:0] val;
    } ev_t;

    logic       clk = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] row_in, col_out, keypad_input;
    logic       read_input, equal_input, clear_out;
    logic [2:0] operator_input;
    logic [3:0] held [4];

    ev_t exp_q[$];
    int  rep_t[$];
    int  total = 0;
    int  bad = 0;
    int  cyc = 0;
    bit  rep_mode = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB), .REPEAT_SCANS(RS)) dut (
        .clk            (clk),
        .RST            (RST),
        .row_in         (row_in),
        .col_out        (col_out),
        .keypad_input   (keypad_input),
        .read_input     (read_input),
        .operator_input (operator_input),
        .equal_input    (equal_input),
        .clear_out      (clear_out)
    );

    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) row_in[r] = ~|(held[r] & ~col_out);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: every strobe is popped from the scoreboard and compared
    always @(negedge clk) begin
        ev_t got;
        if (!RST && (read_input || equal_input || clear_out)) begin
            check("strobe_exclusive", $countones({read_input, equal_input, clear_out}), 1);
            got.kind = read_input ? 2'd0 : equal_input ? 2'd1 : 2'd2;
            got.val  = read_input ? keypad_input : 4'd0;
            if (rep_mode && read_input) begin
                rep_t.push_back(cyc);
                check("repeat_digit", keypad_input, 9);
            end else if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_strobe: got kind=%0d val=%0d expected none", got.kind, got.val);
            end else begin
                check("event", got, exp_q.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic key(input int r, input int c, input int hold);
        held[r][c] = 1'b1;
        tick(hold);
        held[r][c] = 1'b0;
        tick(40);
    endtask

    task automatic push(input logic [1:0] k, input logic [3:0] v);
        exp_q.push_back('{kind: k, val: v});
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick(1);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_col"}, col_out, 4'b1110);
        check({name, "_key"}, keypad_input, 0);
        check({name, "_op"}, operator_input, 0);
        check({name, "_strobes"}, {read_input, equal_input, clear_out}, 0);
    endtask

    initial begin
        int n;
        for (int r = 0; r < 4; r++) held[r] = 4'h0;
        tick(3);
        check_reset_outputs("reset");
        RST = 1'b0;
        tick(20);

        // single long press: one digit, column frozen while held
        push(2'd0, 4'd2);
        held[0][1] = 1'b1;
        tick(100);
        check("t1_col_frozen_a", col_out, 4'b1101);
        tick(99);
        check("t1_col_frozen_b", col_out, 4'b1101);
        held[0][1] = 1'b0;
        tick(40);
        drain("t1_done");

        // short glitch emits nothing, scanning continues
        key(1, 0, 3);
        check("t3_op_none", operator_input, OP_NONE);
        push(2'd0, 4'd5);
        key(1, 1, 60);
        drain("t3_done");

        // digit / operator / equals sequence
        push(2'd0, 4'd1);
        key(0, 0, 60);
        push(2'd0, 4'd2);
        key(0, 1, 60);
        key(0, 3, 60);
        check("t2_op_add", operator_input, OP_ADD);
        push(2'd0, 4'd3);
        key(0, 2, 60);
        push(2'd0, 4'd4);
        key(1, 0, 60);
        push(2'd1, 4'd0);
        key(3, 2, 60);
        check("t2_op_kept", operator_input, OP_ADD);
        check("t2_key_held", keypad_input, 4);
        drain("t2_done");

        // two keys in one column: lowest row wins
        push(2'd0, 4'd1);
        held[2][0] = 1'b1;
        held[0][0] = 1'b1;
        tick(60);
        held[2][0] = 1'b0;
        held[0][0] = 1'b0;
        tick(40);
        key(2, 3, 60);
        check("t4_op_mul", operator_input, OP_MUL);
        drain("t4_done");

        // subtract then clear
        key(1, 3, 60);
        check("t5_op_sub", operator_input, OP_SUB);
        push(2'd2, 4'd0);
        key(3, 0, 60);
        check("t5_op_cleared", operator_input, OP_NONE);
        drain("t5_clear");

        // reset in the middle of debouncing a held 5
        key(0, 3, 60);
        held[1][1] = 1'b1;
        n = 0;
        while (dut.state_q != ST_DEBOUNCE && n < 100) begin
            tick(1);
            n++;
        end
        check("t5_reached_debounce", dut.state_q, ST_DEBOUNCE);
        RST = 1'b1;
        #1;
        check_reset_outputs("t5_async_reset");
        tick(3);
        held[1][1] = 1'b0;
        tick(2);
        RST = 1'b0;
        tick(40);
        push(2'd0, 4'd5);
        key(1, 1, 60);
        drain("t5_fresh_press");

`ifdef KEYPAD_AUTOREPEAT_EN
        // held digit repeats every REPEAT_SCANS dwell samples; equals never repeats
        rep_mode = 1'b1;
        held[2][2] = 1'b1;
        tick(300);
        held[2][2] = 1'b0;
        tick(40);
        rep_mode = 1'b0;
        check("t6_repeat_count", rep_t.size() >= 8, 1);
        for (int i = 1; i < rep_t.size(); i++) check("t6_repeat_gap", rep_t[i] - rep_t[i-1], RS * SD);
        push(2'd1, 4'd0);
        key(3, 2, 300);
        drain("t6_eq_single");
`endif

        tick(20);
        drain("final_empty");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
